key_token_sequencer: RTL and testbench

KEY_TOKEN_SEQUENCER -- requirements
Module: key_token_sequencer

---
 rtl/key_token_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_key_token_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/key_token_sequencer.sv
// key_token_sequencer: turns single-cycle key pulses into a token stream
// (NUM, LPAREN, RPAREN, MINUS, END) with a valid/ready consumer interface.
// Optional build macro KEY_TOKEN_FIFO_EN: 4-entry token FIFO instead of the
// default single-entry output register.
module key_token_sequencer #(
  parameter int NUM_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [9:0]       key_digit,
  input  logic             key_lbracket,
  input  logic             key_rbracket,
  input  logic             key_minus,
  input  logic             key_space,
  input  logic             key_enter,
  output logic             tok_valid,
  output logic [2:0]       tok_type,
  output logic [NUM_W-1:0] tok_value,
  input  logic             tok_ready,
  output logic             num_ovf,
  output logic             key_drop
);

  typedef enum logic [1:0] {IDLE, ACCUM, PEND} state_e;
  typedef enum logic [2:0] {
    TOK_NUM = 3'd0, TOK_LPAREN = 3'd1, TOK_RPAREN = 3'd2,
    TOK_MINUS = 3'd3, TOK_END = 3'd4
  } tok_e;
  typedef enum logic [2:0] {
    EV_NONE, EV_ENTER, EV_RBRACKET, EV_LBRACKET, EV_MINUS, EV_DIGIT, EV_SPACE
  } event_e;

  state_e           state, state_next;
  tok_e             pend_type, pend_next;
  logic [NUM_W-1:0] acc, acc_next;

  event_e           ev;
  logic [3:0]       digit_val;
  logic             any_key;
  logic             is_delim;
  tok_e             delim_tok;
  logic [NUM_W+3:0] prod;

  logic             push;
  tok_e             push_type;
  logic [NUM_W-1:0] push_value;
  logic             ovf_set;
  logic             drop_key;

  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop_full;
  logic             head_valid;
  logic [2:0]       head_type;
  logic [NUM_W-1:0] head_value;

  // Priority arbitration of simultaneous key pulses into a single event.
  always_comb begin
    ev        = EV_NONE;
    digit_val = '0;
    any_key   = (|key_digit) | key_lbracket | key_rbracket | key_minus |
                key_space | key_enter;
    for (int unsigned i = 10; i > 0; i--) begin
      if (key_digit[i-1]) digit_val = 4'(i - 1);
    end
    if (key_enter)           ev = EV_ENTER;
    else if (key_rbracket)   ev = EV_RBRACKET;
    else if (key_lbracket)   ev = EV_LBRACKET;
    else if (key_minus)      ev = EV_MINUS;
    else if (|key_digit)     ev = EV_DIGIT;
    else if (key_space)      ev = EV_SPACE;
  end

  // Map the winning delimiter event to its token type.
  always_comb begin
    is_delim  = 1'b1;
    delim_tok = TOK_END;
    case (ev)
      EV_ENTER:    delim_tok = TOK_END;
      EV_RBRACKET: delim_tok = TOK_RPAREN;
      EV_LBRACKET: delim_tok = TOK_LPAREN;
      EV_MINUS:    delim_tok = TOK_MINUS;
      default:     is_delim  = 1'b0;
    endcase
  end

  // Next-state, accumulator update and token push generation.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    pend_next  = pend_type;
    push       = 1'b0;
    push_type  = TOK_NUM;
    push_value = '0;
    ovf_set    = 1'b0;
    drop_key   = 1'b0;
    prod       = ({4'b0000, acc} * (NUM_W+4)'(10)) + (NUM_W+4)'(digit_val);
    case (state)
      IDLE: begin
        if (ev == EV_DIGIT) begin
          acc_next   = NUM_W'(digit_val);
          state_next = ACCUM;
        end else if (is_delim) begin
          push      = 1'b1;
          push_type = delim_tok;
        end
      end
      ACCUM: begin
        if (ev == EV_DIGIT) begin
          acc_next = prod[NUM_W-1:0];
          ovf_set  = |prod[NUM_W+3:NUM_W];
        end else if (ev == EV_SPACE) begin
          push       = 1'b1;
          push_value = acc;
          state_next = IDLE;
        end else if (is_delim) begin
          push       = 1'b1;
          push_value = acc;
          pend_next  = delim_tok;
          state_next = PEND;
        end
      end
      PEND: begin
        push       = 1'b1;
        push_type  = pend_type;
        drop_key   = any_key;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pop       = head_valid & tok_ready;
  assign push_ok   = push & (~full | pop);
  assign drop_full = push & full & ~pop;

  // FSM state, accumulator, pending delimiter and sticky error flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      pend_type <= TOK_NUM;
      num_ovf   <= 1'b0;
      key_drop  <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      pend_type <= pend_next;
      if (ovf_set) num_ovf <= 1'b1;
      if (drop_key || drop_full) key_drop <= 1'b1;
    end
  end

`ifdef KEY_TOKEN_FIFO_EN
  logic [2:0]       type_mem  [4];
  logic [NUM_W-1:0] value_mem [4];
  logic [1:0]       wr_ptr, rd_ptr;
  logic [2:0]       count;

  assign full       = (count == 3'd4);
  assign head_valid = (count != 3'd0);
  assign head_type  = type_mem[rd_ptr];
  assign head_value = value_mem[rd_ptr];

  // Four-entry circular token FIFO; a write when full only happens alongside
  // a pop, so it lands in the slot being vacated.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        type_mem[wr_ptr]  <= push_type;
        value_mem[wr_ptr] <= push_value;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push_ok) - 3'(pop);
    end
  end
`else
  logic             out_valid;
  logic [2:0]       out_type;
  logic [NUM_W-1:0] out_value;

  assign full       = out_valid;
  assign head_valid = out_valid;
  assign head_type  = out_type;
  assign head_value = out_value;

  // Single-entry output register; a push with a same-cycle pop replaces it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_type  <= '0;
      out_value <= '0;
    end else if (push_ok) begin
      out_valid <= 1'b1;
      out_type  <= push_type;
      out_value <= push_value;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign tok_valid = head_valid;
  assign tok_type  = head_valid ? head_type  : '0;
  assign tok_value = head_valid ? head_value : '0;

endmodule

// File: tb/tb_key_token_sequencer.sv
// Directed self-checking bench for key_token_sequencer (default NUM_W=16).
module tb_key_token_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  key_digit = '0;
  logic        key_lbracket = 1'b0;
  logic        key_rbracket = 1'b0;
  logic        key_minus = 1'b0;
  logic        key_space = 1'b0;
  logic        key_enter = 1'b0;
  logic        tok_valid;
  logic [2:0]  tok_type;
  logic [15:0] tok_value;
  logic        tok_ready = 1'b1;
  logic        num_ovf;
  logic        key_drop;

  int total = 0;
  int bad = 0;

  logic [2:0]  qt [$];
  logic [15:0] qv [$];

  key_token_sequencer #(.NUM_W(16)) dut (
    .clock(clock), .reset(reset), .key_digit(key_digit),
    .key_lbracket(key_lbracket), .key_rbracket(key_rbracket),
    .key_minus(key_minus), .key_space(key_space), .key_enter(key_enter),
    .tok_valid(tok_valid), .tok_type(tok_type), .tok_value(tok_value),
    .tok_ready(tok_ready), .num_ovf(num_ovf), .key_drop(key_drop)
  );

  always #5 clock = ~clock;

  // Record every token handed over to the consumer.
  always @(posedge clock) begin
    if (reset && tok_valid && tok_ready) begin
      qt.push_back(tok_type);
      qv.push_back(tok_value);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tok(input string tag, input int idx, input int typ, input int val);
    if (idx < qt.size()) begin
      chk({tag, "_type"}, 32'(qt[idx]), 32'(typ));
      chk({tag, "_value"}, 32'(qv[idx]), 32'(val));
    end else begin
      chk({tag, "_present"}, 32'(qt.size()), 32'(idx + 1));
    end
  endtask

  task automatic key(input logic [9:0] d, input logic lb, input logic rb,
                     input logic mi, input logic sp, input logic en);
    key_digit = d; key_lbracket = lb; key_rbracket = rb;
    key_minus = mi; key_space = sp; key_enter = en;
    @(posedge clock); #1;
    key_digit = '0; key_lbracket = 0; key_rbracket = 0;
    key_minus = 0; key_space = 0; key_enter = 0;
  endtask

  task automatic dig(input int n);
    logic [9:0] one;
    one = 10'd1;
    key(one << n, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    qt.delete(); qv.delete();
  endtask

  initial begin
    // reset state
    idle(2);
    chk("rst_valid", 32'(tok_valid), 0);
    chk("rst_type", 32'(tok_type), 0);
    chk("rst_value", 32'(tok_value), 0);
    chk("rst_ovf", 32'(num_ovf), 0);
    chk("rst_drop", 32'(key_drop), 0);
    reset = 1'b1;

    // 1,2,3 space -> NUM 123
    dig(1); dig(2); dig(3); key('0, 0, 0, 0, 1, 0);
    chk("n123_not_yet", 32'(qt.size()), 0);
    idle(3);
    chk("n123_count", 32'(qt.size()), 1);
    chk_tok("n123", 0, 0, 123);
    chk("n123_ovf", 32'(num_ovf), 0);

    // [ 4 2 ] enter -> LPAREN NUM42 RPAREN END
    qt.delete(); qv.delete();
    key('0, 1, 0, 0, 0, 0);
    dig(4); dig(2);
    key('0, 0, 1, 0, 0, 0);
    idle(1);
    key('0, 0, 0, 0, 0, 1);
    idle(3);
    chk("brk_count", 32'(qt.size()), 4);
    chk_tok("brk0", 0, 1, 0);
    chk_tok("brk1", 1, 0, 42);
    chk_tok("brk2", 2, 2, 0);
    chk_tok("brk3", 3, 4, 0);
    chk("brk_drop", 32'(key_drop), 0);

    // 65536 wraps to 0 and sets sticky overflow
    qt.delete(); qv.delete();
    dig(6); dig(5); dig(5); dig(3); dig(6); key('0, 0, 0, 0, 1, 0);
    idle(3);
    chk("ovf_count", 32'(qt.size()), 1);
    chk_tok("ovf", 0, 0, 0);
    chk("ovf_flag", 32'(num_ovf), 1);
    dig(1); key('0, 0, 0, 0, 1, 0); idle(3);
    chk("ovf_sticky", 32'(num_ovf), 1);
    chk_tok("ovf_next", 1, 0, 1);
    do_reset();
    chk("ovf_clr", 32'(num_ovf), 0);

    // storage full with consumer stalled
    tok_ready = 1'b0;
`ifdef KEY_TOKEN_FIFO_EN
    repeat (5) key('0, 1, 0, 0, 0, 0);
`else
    repeat (2) key('0, 1, 0, 0, 0, 0);
`endif
    chk("full_drop", 32'(key_drop), 1);
    chk("full_valid", 32'(tok_valid), 1);
    chk("full_type", 32'(tok_type), 1);
    idle(3);
    chk("full_hold_valid", 32'(tok_valid), 1);
    chk("full_hold_type", 32'(tok_type), 1);
    tok_ready = 1'b1;
    idle(6);
`ifdef KEY_TOKEN_FIFO_EN
    chk("full_drained", 32'(qt.size()), 4);
    chk_tok("full3", 3, 1, 0);
`else
    chk("full_drained", 32'(qt.size()), 1);
`endif
    chk_tok("full0", 0, 1, 0);
    chk("full_empty", 32'(tok_valid), 0);
    do_reset();
    chk("drop_clr", 32'(key_drop), 0);

    // digit 7 + minus same cycle -> MINUS only; enter+rbracket -> END only
    key(10'b0010000000, 0, 0, 1, 0, 0);
    key('0, 0, 1, 0, 0, 1);
    idle(3);
    chk("prio_count", 32'(qt.size()), 2);
    chk_tok("prio0", 0, 3, 0);
    chk_tok("prio1", 1, 4, 0);
    chk("prio_drop", 32'(key_drop), 0);

    // 7, minus, lbracket during PEND -> NUM 7, MINUS, key_drop
    qt.delete(); qv.delete();
    dig(7);
    key('0, 0, 0, 1, 0, 0);
    key('0, 1, 0, 0, 0, 0);
    idle(3);
    chk("pend_count", 32'(qt.size()), 2);
    chk_tok("pend0", 0, 0, 7);
    chk_tok("pend1", 1, 3, 0);
    chk("pend_drop", 32'(key_drop), 1);
    do_reset();

    // reset mid-number discards literal; following space does nothing
    dig(9); dig(9);
    do_reset();
    key('0, 0, 0, 0, 1, 0);
    idle(3);
    chk("rmid_count", 32'(qt.size()), 0);
    chk("rmid_valid", 32'(tok_valid), 0);
    chk("rmid_ovf", 32'(num_ovf), 0);
    chk("rmid_drop", 32'(key_drop), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
